// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared receiver state, scancode constants and key-map lookup
package ps2_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        KEY_P1P,
        KEY_P1M,
        KEY_P2P,
        KEY_P2M,
        KEY_SERVE,
        KEY_START,
        KEY_NONE
    } key_idx_t;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;

    // The extended flag must match exactly: bare 75 is keypad 8, not the up arrow.
    function automatic key_idx_t key_lookup(input logic [7:0] sc, input logic ext);
        key_idx_t k;
        k = KEY_NONE;
        if (!ext) begin
            case (sc)
                SC_W:     k = KEY_P1P;
                SC_S:     k = KEY_P1M;
                SC_SPACE: k = KEY_SERVE;
                SC_ENTER: k = KEY_START;
                default:  k = KEY_NONE;
            endcase
        end else begin
            case (sc)
                SC_UP:    k = KEY_P2P;
                SC_DOWN:  k = KEY_P2M;
                default:  k = KEY_NONE;
            endcase
        end
        return k;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - PS/2 frame receiver: sync, edge detect, FSM, timeout, parity
// Optional odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data,
    output logic       valid,
    output logic       err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    rx_state_t     state;
    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_prev;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [CW-1:0] idle_cnt;
    logic          fall;
    logic          sdata;
    logic          timeout;
    logic          par_ok;
`ifdef PS2_PARITY_CHECK_EN
    logic          par;
    assign par_ok = ^{shreg, par};
`else
    assign par_ok = 1'b1;
`endif

    assign fall    = clk_prev & ~clk_sync[1];
    assign sdata   = data_sync[1];
    assign timeout = (state != RX_IDLE) && !fall && (idle_cnt == LAST);
    assign data    = shreg;

    // Completion and error are strobes in the stop-edge cycle; the top registers them.
    always_comb begin
        valid = 1'b0;
        err   = 1'b0;
        if (timeout) begin
            err = 1'b1;
        end else if (fall && state == RX_STOP) begin
            if (sdata && par_ok) valid = 1'b1;
            else                 err   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RX_IDLE;
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            idle_cnt  <= '0;
`ifdef PS2_PARITY_CHECK_EN
            par       <= 1'b0;
`endif
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];

            if (state != RX_IDLE && !fall) idle_cnt <= idle_cnt + 1'b1;
            else                           idle_cnt <= '0;

            if (timeout) begin
                state <= RX_IDLE;
            end else if (fall) begin
                case (state)
                    RX_IDLE: begin
                        if (!sdata) begin
                            state   <= RX_DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    RX_DATA: begin
                        shreg   <= {sdata, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= RX_PARITY;
                    end
                    RX_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        par   <= sdata;
`endif
                        state <= RX_STOP;
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 scancode decoder driving paddle/serve/start key levels
// Parity checking in the receiver is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       p1p,
    output logic       p1m,
    output logic       p2p,
    output logic       p2m,
    output logic       serve_n,
    output logic       start_n,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err
);

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic       ext;
    logic       brk;

    ps2_rx_frame #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .data     (rx_data),
        .valid    (rx_valid),
        .err      (rx_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1p        <= 1'b0;
            p1m        <= 1'b0;
            p2p        <= 1'b0;
            p2m        <= 1'b0;
            serve_n    <= 1'b1;
            start_n    <= 1'b1;
            code       <= 8'h00;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            ext        <= 1'b0;
            brk        <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (rx_err) begin
                frame_err <= 1'b1;
                ext       <= 1'b0;
                brk       <= 1'b0;
            end else if (rx_valid) begin
                code       <= rx_data;
                code_valid <= 1'b1;
                if (rx_data == SC_EXT) begin
                    ext <= 1'b1;
                end else if (rx_data == SC_BRK) begin
                    brk <= 1'b1;
                end else begin
                    // Active-low outputs take brk directly: make -> 0, break -> 1.
                    case (key_lookup(rx_data, ext))
                        KEY_P1P:   p1p     <= ~brk;
                        KEY_P1M:   p1m     <= ~brk;
                        KEY_P2P:   p2p     <= ~brk;
                        KEY_P2M:   p2m     <= ~brk;
                        KEY_SERVE: serve_n <= brk;
                        KEY_START: start_n <= brk;
                        default:   ;
                    endcase
                    ext <= 1'b0;
                    brk <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning clk cycles without a PS/2 clock falling edge before an open frame is aborted (2 ms at 50 MHz).
REQ-002 SHALL have port clk  input  1  system clock; the block's only clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports ps2_clk, ps2_data  input  1 each  raw keyboard lines, asynchronous to clk.
REQ-005 SHALL have ports p1p, p1m, p2p, p2m  output  1 each  paddle key held levels, active-high.
REQ-006 SHALL have ports serve_n, start_n  output  1 each  serve and start key held levels, active-low.
REQ-007 SHALL have port code  output  8  last received data byte.
REQ-008 SHALL have port code_valid  output  1  one-cycle pulse when code is updated.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on a discarded frame.

Function
REQ-010 SHALL pass ps2_clk and ps2_data through two-flop synchronizers, and SHALL detect a falling edge as sync'd ps2_clk going 1 to 0.
REQ-011 SHALL sample ps2_data on each falling edge; frame = start(0), 8 data bits LSB first, odd parity, stop(1).
REQ-012 SHALL run a receiver FSM with states IDLE, DATA, PARITY, STOP.
- IDLE->DATA on an edge with data 0; an edge with data 1 in IDLE is ignored, no error.
- DATA->PARITY after the 8th bit; PARITY->STOP after the parity bit; STOP->IDLE on the next edge.
REQ-013 SHALL treat stop bit 0 as a frame error: frame_err pulses and the byte is discarded.
REQ-014 SHALL count clk cycles since the last edge while not in IDLE; on reaching TIMEOUT_CYCLES, SHALL return to IDLE and pulse frame_err.
REQ-015 SHALL, for an accepted frame, load code and pulse code_valid in the cycle after the stop-bit edge is detected.
REQ-016 SHALL set flag ext on byte E0 and flag brk on byte F0, accepting both in either order, and SHALL NOT change any key output on a prefix byte.
REQ-017 SHALL, on a non-prefix byte, set the mapped key level to !brk, update it in the same cycle as code_valid, and then clear ext and brk.
REQ-018 SHALL use this key map: 1D (W)->p1p; 1B (S)->p1m; E0 75 (up)->p2p; E0 72 (down)->p2m; 29 (space)->serve; 5A (enter)->start; ext must match exactly.
REQ-019 SHALL leave levels unchanged for an unmapped byte or a mismatched ext, while still clearing ext and brk.
REQ-020 SHALL keep a level at 1 on a repeated make (typematic); a break for a key not held SHALL leave it at 0.
REQ-021 SHALL clear ext and brk on frame_err.

Reset
REQ-022 SHALL, while rst is high: FSM=IDLE; counters, ext, brk and synchronizers cleared (ps2 sync flops to 1).
REQ-023 SHALL drive these reset values: p1p=p1m=p2p=p2m=0, serve_n=start_n=1, code=00, code_valid=0, frame_err=0.
REQ-024 SHALL discard a frame in progress when rst asserts; no code_valid or frame_err results from that frame.

Configuration
REQ-025 SHALL, with PS2_PARITY_CHECK_EN defined, check odd parity; a mismatch discards the byte and pulses frame_err as in REQ-013.
REQ-026 SHALL, without PS2_PARITY_CHECK_EN, ignore the parity bit and never raise frame_err for parity.

Structure
REQ-027 SHALL place in shared package ps2_pkg: the receiver state enum, the scancode constants (E0, F0, 1D, 1B, 75, 72, 29, 5A), and the key-index typedef.
REQ-028 SHALL implement the frame receiver (sync, edge detect, FSM, timeout, parity) as sub-module ps2_rx_frame, and SHALL keep prefix and key-map decode in ps2_key_decoder.

Verification
REQ-029 SHALL cover: frame 1D, valid parity -> code=1D, code_valid 1 cycle, p1p=1; then F0,1D -> p1p=0.
REQ-030 SHALL cover: E0 75 then E0 F0 75 -> p2p 1 then 0; bare 75 leaves p2p=0.
REQ-031 SHALL cover: 5A, then 29 -> start_n=0, serve_n=0; then F0 29 -> serve_n=1, start_n stays 0.
REQ-032 SHALL cover: frame 1D with stop bit 0 -> frame_err pulse, no code_valid, p1p stays 0; with the macro defined, bad parity on 1B -> frame_err, p1m stays 0.
REQ-033 SHALL cover: 4 data bits then silence for TIMEOUT_CYCLES -> frame_err and return to IDLE; the next full frame 1B -> p1m=1.
REQ-034 SHALL cover: rst asserted mid-frame after p1p=1 -> all outputs at reset values, and the following complete frame is decoded correctly.
